// File: rtl/gpu_pkg.sv
// Shared GPU types: rect-fill FSM states, RGB444 colour and default display geometry.
package gpu_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} rect_state_t;
  typedef logic [11:0] color_t;

  localparam int H_RES_DEF   = 80;
  localparam int V_RES_DEF   = 60;
  localparam int VRAM_ADDR_W = 16;
endpackage

// File: rtl/gpu_rect_fill_addr_gen.sv
// Raster cursor for the rect-fill engine: loads origin/size, advances one pixel per step.
// Effective-size clipping to H_RES x V_RES only when GPU_RECT_FILL_CLIP_EN is defined.
module rect_addr_gen
  import gpu_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last,
  output logic           zero
);
  logic [X_W-1:0] w_eff;
  logic [Y_W-1:0] h_eff;
  logic [X_W-1:0] x0_q, x_last_q;
  logic [Y_W-1:0] y_last_q;
  logic           row_end;

  if (H_RES > (1 << X_W) || V_RES > (1 << Y_W)) begin : g_res_chk
    $error("gpu_rect_fill: H_RES/V_RES exceed the coordinate field width");
  end

`ifdef GPU_RECT_FILL_CLIP_EN
  logic [X_W:0] room_x;
  logic [Y_W:0] room_y;

  assign room_x = (X_W+1)'(H_RES) - {1'b0, x0};
  assign room_y = (Y_W+1)'(V_RES) - {1'b0, y0};

  // An origin outside the visible area collapses to a zero-size command.
  always_comb begin
    w_eff = w;
    h_eff = h;
    if ({1'b0, x0} >= (X_W+1)'(H_RES))  w_eff = '0;
    else if ({1'b0, w} > room_x)        w_eff = room_x[X_W-1:0];
    if ({1'b0, y0} >= (Y_W+1)'(V_RES))  h_eff = '0;
    else if ({1'b0, h} > room_y)        h_eff = room_y[Y_W-1:0];
  end
`else
  assign w_eff = w;
  assign h_eff = h;
`endif

  assign zero    = (w_eff == '0) || (h_eff == '0);
  assign row_end = (x == x_last_q);
  assign last    = row_end && (y == y_last_q);

  // End coordinates wrap modulo the field width, so equality compare handles wrap-around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      x0_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x0_q     <= x0;
      x_last_q <= x0 + w_eff - (X_W)'(1);
      y_last_q <= y0 + h_eff - (Y_W)'(1);
    end else if (step) begin
      if (row_end) begin
        x <= x0_q;
        y <= y + (Y_W)'(1);
      end else begin
        x <= x + (X_W)'(1);
      end
    end
  end
endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: one VRAM write per granted cycle, first write the cycle after accept,
// grant-low holds the write stable; done_o pulses once. Clipping under GPU_RECT_FILL_CLIP_EN.
module gpu_rect_fill
  import gpu_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [X_W-1:0]     cmd_x_i,
  input  logic [Y_W-1:0]     cmd_y_i,
  input  logic [X_W-1:0]     cmd_w_i,
  input  logic [Y_W-1:0]     cmd_h_i,
  input  logic [11:0]        cmd_color_i,
  output logic               vram_we_o,
  input  logic               vram_gnt_i,
  output logic [X_W+Y_W-1:0] vram_addr_o,
  output logic [11:0]        vram_data_o,
  output logic               busy_o,
  output logic               done_o
);
  rect_state_t    state, state_nxt;
  color_t         color_q;
  logic           load, step, last, zero;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;

  rect_addr_gen #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .step (step),
    .x0   (cmd_x_i),
    .y0   (cmd_y_i),
    .w    (cmd_w_i),
    .h    (cmd_h_i),
    .x    (cur_x),
    .y    (cur_y),
    .last (last),
    .zero (zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (cmd_valid_i) begin
        load      = 1'b1;
        state_nxt = zero ? DONE : FILL;
      end
      FILL: if (vram_gnt_i) begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      color_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) color_q <= cmd_color_i;
    end
  end

  // Outputs decode flops only; the grant never reaches them combinationally.
  assign cmd_ready_o = (state == IDLE);
  assign vram_we_o   = (state == FILL);
  assign busy_o      = (state == FILL);
  assign done_o      = (state == DONE);
  assign vram_addr_o = {cur_y, cur_x};
  assign vram_data_o = color_q;
endmodule

// File: doc/gpu_rect_fill.md
# gpu_rect_fill

Hardware rectangle-fill engine between the OTTER IOBUS register file and the GPU VRAM write port. The CPU latches one command (origin, size, 12-bit colour) and the engine streams one VRAM write per granted cycle in raster order. The CPU therefore no longer issues one IOBUS store per pixel. A `done_o` pulse is ORed into the MCU interrupt alongside the timer-counter interrupt.

## Interface
Parameters:
- `X_W`, default 8: x coordinate width; VRAM address low field.
- `Y_W`, default 8: y coordinate width; VRAM address high field.
- `H_RES`, default 80: visible columns (clip bound).
- `V_RES`, default 60: visible rows (clip bound).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (50 MHz `s_clk` domain)
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid_i`  in  1  command strobe
- `cmd_ready_o`  out  1  engine idle, command accepted when `cmd_valid_i` is also high
- `cmd_x_i`  in  X_W  origin x
- `cmd_y_i`  in  Y_W  origin y
- `cmd_w_i`  in  X_W  width in pixels
- `cmd_h_i`  in  Y_W  height in pixels
- `cmd_color_i`  in  12  RGB444 fill colour
- `vram_we_o`  out  1  write request
- `vram_gnt_i`  in  1  write granted this cycle (low while a CPU direct write owns the port)
- `vram_addr_o`  out  X_W+Y_W  `{y, x}`
- `vram_data_o`  out  12  colour
- `busy_o`  out  1  command in progress
- `done_o`  out  1  single-cycle completion pulse

## Operation
- Reset values: `cmd_ready_o`=1, `vram_we_o`=0, `vram_addr_o`=0, `vram_data_o`=0, `busy_o`=0, `done_o`=0. The FSM resets to IDLE.
- FSM has three states: IDLE, FILL, DONE.
- **IDLE:**
  - `cmd_ready_o`=1.
  - On accept, latch x0, y0, w, h and colour. Load cursor x=x0, y=y0.
  - If the effective w or h is 0, go to DONE. Otherwise go to FILL.
- **FILL:**
  - `vram_we_o`=1, `busy_o`=1. Address and data reflect the cursor.
  - A pixel retires only on a cycle with `vram_we_o && vram_gnt_i`. While the grant is low, address, data and `vram_we_o` are held stable.
  - On retire, x increments. When x reaches x0+w_eff-1, x reloads x0 and y increments.
  - Retiring the last pixel (x0+w_eff-1, y0+h_eff-1) moves the FSM to DONE.
- **DONE:** `done_o`=1 for exactly one cycle, `busy_o`=0, `vram_we_o`=0. Next state is IDLE.
- Commands presented while not in IDLE are ignored (`cmd_ready_o`=0). They are not queued.
- Without clipping, all coordinate arithmetic is modulo 2^X_W and 2^Y_W. Regions wrap around the VRAM address field.
- If reset asserts mid-fill, the engine aborts immediately. No further writes occur and no `done_o` pulse is produced.

## Timing
- A command accepted at edge t places the first write on the port at t+1.
- With continuous grant, w×h pixels take w×h cycles. `done_o` is high in cycle t+1+w×h. `cmd_ready_o` returns high the following cycle.
- A zero-size command gives `done_o` at t+1 and no writes.
- Every de-asserted grant cycle adds exactly one cycle of latency.
- All outputs are registered; there is no combinational path from `vram_gnt_i` to the outputs.

## Configuration
- **`GPU_RECT_FILL_CLIP_EN` defined:**
  - w_eff = min(w, H_RES−x0) and h_eff = min(h, V_RES−y0).
  - If x0 ≥ H_RES or y0 ≥ V_RES, the command completes as zero-size.
  - No write ever targets x ≥ H_RES or y ≥ V_RES.
- **Macro undefined:** w_eff=w, h_eff=h, and the wrap-around behaviour above applies. This saves the comparators and subtractors.

## Structure
- Shared `gpu_pkg`:
  - `rect_state_t` enum (IDLE/FILL/DONE)
  - `color_t` (logic [11:0])
  - default `H_RES`/`V_RES` constants
  - `VRAM_ADDR_W` = 16
- Sub-module `rect_addr_gen`: x/y cursor counters, end-of-row and last-pixel detection, and effective-size clip logic. It advances on a `step` input.

## Test plan
- **Basic fill:** cmd (x=2, y=3, w=3, h=2, colour=0xF00) with grant held high → writes at addr 0x0302, 0x0303, 0x0304, 0x0402, 0x0403, 0x0404, data 0xF00; `done_o` exactly 7 cycles after accept.
- **Grant stall:** same command with `vram_gnt_i` low for 2 cycles at the third pixel → addr 0x0304 held for 3 cycles; exactly 6 writes total; `done_o` delayed by 2 cycles.
- **Zero size:** w=0, h=5 → no `vram_we_o`; `done_o` 1 cycle after accept.
- **Clip** (`GPU_RECT_FILL_CLIP_EN`): x=78, y=59, w=4, h=4 → only 0x3B4E and 0x3B4F written. Without the macro: 16 writes, x wraps past 0xFF only when x0+w > 256.
- **Reset mid-fill:** `rst_n` low after 3 writes → outputs return to reset values asynchronously, no `done_o`, `cmd_ready_o`=1 after release.
- **Busy reject:** second `cmd_valid_i` during FILL → ignored; first command completes unchanged.
